// File: rtl/add_arbiter.sv
// Two-requester arbiter that time-shares an external combinational 16-bit add/sub unit.
// It uses a round-robin grant, one registered operand stage, and one held response register per requester.
module add_arbiter #(
    parameter bit SAT_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_vld,
    input  logic [15:0] req0_A,
    input  logic [15:0] req0_B,
    input  logic        req0_sub,
    output logic        req0_rdy,
    input  logic        req1_vld,
    input  logic [15:0] req1_A,
    input  logic [15:0] req1_B,
    input  logic        req1_sub,
    output logic        req1_rdy,
    output logic        rsp0_vld,
    output logic [15:0] rsp0_sum,
    output logic        rsp0_pos_ovfl,
    output logic        rsp0_neg_ovfl,
    input  logic        rsp0_rdy,
    output logic        rsp1_vld,
    output logic [15:0] rsp1_sum,
    output logic        rsp1_pos_ovfl,
    output logic        rsp1_neg_ovfl,
    input  logic        rsp1_rdy,
    output logic [15:0] add_A,
    output logic [15:0] add_B,
    output logic        add_sub,
    input  logic [15:0] add_sum,
    input  logic        add_pos_ovfl,
    input  logic        add_neg_ovfl
);

    logic [1:0]       busy_q, busy_d;
    logic             rr_q, rr_d;
    logic             s1_vld_q, s1_vld_d;
    logic [15:0]      s1_a_q, s1_a_d;
    logic [15:0]      s1_b_q, s1_b_d;
    logic             s1_sub_q, s1_sub_d;
    logic             s1_id_q, s1_id_d;
    logic [1:0]       rsp_vld_q, rsp_vld_d;
    logic [1:0]       rsp_pos_q, rsp_pos_d;
    logic [1:0]       rsp_neg_q, rsp_neg_d;
    logic [1:0][15:0] rsp_sum_q, rsp_sum_d;

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       handoff;
    logic [15:0]      result;

    // Eligibility uses the registered busy bit, so a requester cannot be re-granted in its handoff cycle.
    always_comb begin
        elig  = {req1_vld, req0_vld} & ~busy_q;
        grant = 2'b00;
        if (!rst) begin
            if (elig == 2'b11) begin
                grant = rr_q ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    assign handoff = rsp_vld_q & {rsp1_rdy, rsp0_rdy};

    always_comb begin
        result = add_sum;
        if (SAT_EN && add_pos_ovfl) begin
            result = 16'h7FFF;
        end else if (SAT_EN && add_neg_ovfl) begin
            result = 16'h8000;
        end
    end

    always_comb begin
        busy_d    = (busy_q & ~handoff) | grant;
        rr_d      = rr_q;
        s1_vld_d  = |grant;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_sub_d  = s1_sub_q;
        s1_id_d   = s1_id_q;
        rsp_vld_d = rsp_vld_q & ~handoff;
        rsp_sum_d = rsp_sum_q;
        rsp_pos_d = rsp_pos_q;
        rsp_neg_d = rsp_neg_q;
        if (grant[0]) begin
            s1_a_d   = req0_A;
            s1_b_d   = req0_B;
            s1_sub_d = req0_sub;
            s1_id_d  = 1'b0;
            rr_d     = 1'b1;
        end else if (grant[1]) begin
            s1_a_d   = req1_A;
            s1_b_d   = req1_B;
            s1_sub_d = req1_sub;
            s1_id_d  = 1'b1;
            rr_d     = 1'b0;
        end
        // The owner's response slot is always free here because busy blocks a second operation.
        if (s1_vld_q) begin
            rsp_vld_d[s1_id_q] = 1'b1;
            rsp_sum_d[s1_id_q] = result;
            rsp_pos_d[s1_id_q] = add_pos_ovfl;
            rsp_neg_d[s1_id_q] = add_neg_ovfl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 2'b00;
            rr_q      <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_a_q    <= 16'h0000;
            s1_b_q    <= 16'h0000;
            s1_sub_q  <= 1'b0;
            s1_id_q   <= 1'b0;
            rsp_vld_q <= 2'b00;
            rsp_sum_q <= '0;
            rsp_pos_q <= 2'b00;
            rsp_neg_q <= 2'b00;
        end else begin
            busy_q    <= busy_d;
            rr_q      <= rr_d;
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_sub_q  <= s1_sub_d;
            s1_id_q   <= s1_id_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_pos_q <= rsp_pos_d;
            rsp_neg_q <= rsp_neg_d;
        end
    end

    assign req0_rdy      = grant[0];
    assign req1_rdy      = grant[1];
    assign add_A         = s1_vld_q ? s1_a_q : 16'h0000;
    assign add_B         = s1_vld_q ? s1_b_q : 16'h0000;
    assign add_sub       = s1_vld_q & s1_sub_q;
    assign rsp0_vld      = rsp_vld_q[0];
    assign rsp1_vld      = rsp_vld_q[1];
    assign rsp0_sum      = rsp_sum_q[0];
    assign rsp1_sum      = rsp_sum_q[1];
    assign rsp0_pos_ovfl = rsp_pos_q[0];
    assign rsp1_pos_ovfl = rsp_pos_q[1];
    assign rsp0_neg_ovfl = rsp_neg_q[0];
    assign rsp1_neg_ovfl = rsp_neg_q[1];

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: a wrapping instance and a saturating instance share one stimulus stream.
// Each instance has its own behavioural add/sub unit.
module tb_add_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0Vld = 1'b0, req1Vld = 1'b0, req0Sub = 1'b0, req1Sub = 1'b0;
    logic [15:0] req0A = '0, req0B = '0, req1A = '0, req1B = '0;
    logic        rsp0Rdy = 1'b0, rsp1Rdy = 1'b0;

    logic        wReq0Rdy, wReq1Rdy, wRsp0Vld, wRsp1Vld, wRsp0Pos, wRsp0Neg, wRsp1Pos, wRsp1Neg;
    logic [15:0] wRsp0Sum, wRsp1Sum, wAddA, wAddB, wAddSum;
    logic        wAddSub, wAddPos, wAddNeg;
    logic        sReq0Rdy, sReq1Rdy, sRsp0Vld, sRsp1Vld, sRsp0Pos, sRsp0Neg, sRsp1Pos, sRsp1Neg;
    logic [15:0] sRsp0Sum, sRsp1Sum, sAddA, sAddB, sAddSum;
    logic        sAddSub, sAddPos, sAddNeg;

    int testsRun = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    assign wAddSum = wAddSub ? wAddA - wAddB : wAddA + wAddB;
    assign wAddPos = ~wAddA[15] & (wAddSub ? wAddB[15] : ~wAddB[15]) & wAddSum[15];
    assign wAddNeg = wAddA[15] & (wAddSub ? ~wAddB[15] : wAddB[15]) & ~wAddSum[15];
    assign sAddSum = sAddSub ? sAddA - sAddB : sAddA + sAddB;
    assign sAddPos = ~sAddA[15] & (sAddSub ? sAddB[15] : ~sAddB[15]) & sAddSum[15];
    assign sAddNeg = sAddA[15] & (sAddSub ? ~sAddB[15] : sAddB[15]) & ~sAddSum[15];

    add_arbiter #(.SAT_EN(1'b0)) dutWrap (
        .clk(clk), .rst(rst),
        .req0_vld(req0Vld), .req0_A(req0A), .req0_B(req0B), .req0_sub(req0Sub), .req0_rdy(wReq0Rdy),
        .req1_vld(req1Vld), .req1_A(req1A), .req1_B(req1B), .req1_sub(req1Sub), .req1_rdy(wReq1Rdy),
        .rsp0_vld(wRsp0Vld), .rsp0_sum(wRsp0Sum), .rsp0_pos_ovfl(wRsp0Pos), .rsp0_neg_ovfl(wRsp0Neg),
        .rsp0_rdy(rsp0Rdy),
        .rsp1_vld(wRsp1Vld), .rsp1_sum(wRsp1Sum), .rsp1_pos_ovfl(wRsp1Pos), .rsp1_neg_ovfl(wRsp1Neg),
        .rsp1_rdy(rsp1Rdy),
        .add_A(wAddA), .add_B(wAddB), .add_sub(wAddSub),
        .add_sum(wAddSum), .add_pos_ovfl(wAddPos), .add_neg_ovfl(wAddNeg)
    );

    add_arbiter #(.SAT_EN(1'b1)) dutSat (
        .clk(clk), .rst(rst),
        .req0_vld(req0Vld), .req0_A(req0A), .req0_B(req0B), .req0_sub(req0Sub), .req0_rdy(sReq0Rdy),
        .req1_vld(req1Vld), .req1_A(req1A), .req1_B(req1B), .req1_sub(req1Sub), .req1_rdy(sReq1Rdy),
        .rsp0_vld(sRsp0Vld), .rsp0_sum(sRsp0Sum), .rsp0_pos_ovfl(sRsp0Pos), .rsp0_neg_ovfl(sRsp0Neg),
        .rsp0_rdy(rsp0Rdy),
        .rsp1_vld(sRsp1Vld), .rsp1_sum(sRsp1Sum), .rsp1_pos_ovfl(sRsp1Pos), .rsp1_neg_ovfl(sRsp1Neg),
        .rsp1_rdy(rsp1Rdy),
        .add_A(sAddA), .add_B(sAddB), .add_sub(sAddSub),
        .add_sum(sAddSum), .add_pos_ovfl(sAddPos), .add_neg_ovfl(sAddNeg)
    );

    // Expected {pos, neg, sum} computed from the signed integer value of the operation.
    function automatic logic [17:0] refResult(input logic [15:0] a, input logic [15:0] b,
                                              input logic sub, input bit sat);
        int r;
        logic pos, neg;
        logic [15:0] s;
        r   = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        pos = (r > 32767);
        neg = (r < -32768);
        s   = r[15:0];
        if (sat && pos) s = 16'h7FFF;
        else if (sat && neg) s = 16'h8000;
        return {pos, neg, s};
    endfunction

    function automatic logic [15:0] pickOp();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the edge that starts the first post-reset cycle, with idle inputs.
    task automatic doReset();
        nextCycle();
        rst = 1'b1;
        req0Vld = 1'b0; req1Vld = 1'b0; rsp0Rdy = 1'b0; rsp1Rdy = 1'b0;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        req0Vld = 1'b1; req0A = 16'h0001; req0B = 16'h0001; req0Sub = 1'b0;
        nextCycle();
        req0Vld = 1'b0;
        repeat (3) nextCycle();
        rst = 1'b1; req0Vld = 1'b1; req1Vld = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_cycle_rdy: got %b expected 0000", {wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy});
        end
        nextCycle();
        rst = 1'b0; req0Vld = 1'b0; req1Vld = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy, wRsp0Vld, wRsp1Vld, sRsp0Vld, sRsp1Vld} !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL post_reset_rdy_vld: got %b expected 00000000",
                     {wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy, wRsp0Vld, wRsp1Vld, sRsp0Vld, sRsp1Vld});
        end
        testsRun++;
        if ({wAddA, wAddB, wAddSub, sAddA, sAddB, sAddSub} !== 66'h0) begin
            failCount++;
            $display("[TB] FAIL post_reset_add: got %h %h %b / %h %h %b expected zeros",
                     wAddA, wAddB, wAddSub, sAddA, sAddB, sAddSub);
        end
        testsRun++;
        if ({wRsp0Sum, wRsp1Sum, sRsp0Sum, sRsp1Sum, wRsp0Pos, wRsp0Neg, wRsp1Pos, wRsp1Neg,
             sRsp0Pos, sRsp0Neg, sRsp1Pos, sRsp1Neg} !== 72'h0) begin
            failCount++;
            $display("[TB] FAIL post_reset_rsp: got sums %h %h %h %h expected zeros",
                     wRsp0Sum, wRsp1Sum, sRsp0Sum, sRsp1Sum);
        end
    endtask

    task automatic test_single_add();
        doReset();
        req0Vld = 1'b1; req0A = 16'h0003; req0B = 16'h0004; req0Sub = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy} !== 4'b1010) begin
            failCount++;
            $display("[TB] FAIL single_grant: got %b expected 1010", {wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy});
        end
        nextCycle();
        req0Vld = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, wAddA, wAddB, wAddSub} !== {1'b0, 16'h0003, 16'h0004, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL single_stage1: got vld=%b A=%h B=%h sub=%b expected 0 0003 0004 0",
                     wRsp0Vld, wAddA, wAddB, wAddSub);
        end
        nextCycle();
        rsp0Rdy = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, wRsp0Pos, wRsp0Neg, wRsp0Sum, sRsp0Vld, sRsp0Pos, sRsp0Neg, sRsp0Sum} !==
            {3'b100, 16'h0007, 3'b100, 16'h0007}) begin
            failCount++;
            $display("[TB] FAIL single_result: got %b %h / %b %h expected 100 0007",
                     {wRsp0Vld, wRsp0Pos, wRsp0Neg}, wRsp0Sum, {sRsp0Vld, sRsp0Pos, sRsp0Neg}, sRsp0Sum);
        end
        nextCycle();
        rsp0Rdy = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, sRsp0Vld} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL single_vld_clear: got %b expected 00", {wRsp0Vld, sRsp0Vld});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, b0, a1, b1;
        logic s0, s1;
        a0 = pickOp(); b0 = pickOp(); a1 = pickOp(); b1 = pickOp();
        s0 = 1'($urandom); s1 = 1'($urandom);
        doReset();
        req0Vld = 1'b1; req0A = a0; req0B = b0; req0Sub = s0;
        req1Vld = 1'b1; req1A = a1; req1B = b1; req1Sub = s1;
        rsp0Rdy = 1'b1; rsp1Rdy = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy} !== 4'b1010) begin
            failCount++;
            $display("[TB] FAIL b2b_first_grant: got %b expected 1010", {wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy});
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if ({wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy} !== 4'b0101) begin
            failCount++;
            $display("[TB] FAIL b2b_second_grant: got %b expected 0101", {wReq0Rdy, wReq1Rdy, sReq0Rdy, sReq1Rdy});
        end
        nextCycle();
        req0Vld = 1'b0; req1Vld = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, wRsp1Vld, sRsp0Vld, sRsp1Vld} !== 4'b1010) begin
            failCount++;
            $display("[TB] FAIL b2b_rsp0_timing: got %b expected 1010", {wRsp0Vld, wRsp1Vld, sRsp0Vld, sRsp1Vld});
        end
        testsRun++;
        if ({wRsp0Pos, wRsp0Neg, wRsp0Sum, sRsp0Pos, sRsp0Neg, sRsp0Sum} !==
            {refResult(a0, b0, s0, 1'b0), refResult(a0, b0, s0, 1'b1)}) begin
            failCount++;
            $display("[TB] FAIL b2b_rsp0_value: got %h / %h expected %h / %h",
                     {wRsp0Pos, wRsp0Neg, wRsp0Sum}, {sRsp0Pos, sRsp0Neg, sRsp0Sum},
                     refResult(a0, b0, s0, 1'b0), refResult(a0, b0, s0, 1'b1));
        end
        nextCycle();
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, wRsp1Vld, sRsp0Vld, sRsp1Vld} !== 4'b0101) begin
            failCount++;
            $display("[TB] FAIL b2b_rsp1_timing: got %b expected 0101", {wRsp0Vld, wRsp1Vld, sRsp0Vld, sRsp1Vld});
        end
        testsRun++;
        if ({wRsp1Pos, wRsp1Neg, wRsp1Sum, sRsp1Pos, sRsp1Neg, sRsp1Sum} !==
            {refResult(a1, b1, s1, 1'b0), refResult(a1, b1, s1, 1'b1)}) begin
            failCount++;
            $display("[TB] FAIL b2b_rsp1_value: got %h / %h expected %h / %h",
                     {wRsp1Pos, wRsp1Neg, wRsp1Sum}, {sRsp1Pos, sRsp1Neg, sRsp1Sum},
                     refResult(a1, b1, s1, 1'b0), refResult(a1, b1, s1, 1'b1));
        end
        nextCycle();
        rsp0Rdy = 1'b0; rsp1Rdy = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] opA [2] = '{16'h7FFF, 16'h8000};
        logic [15:0] opB [2] = '{16'h0001, 16'h0001};
        logic        opS [2] = '{1'b0, 1'b1};
        logic [17:0] expW [2] = '{{2'b10, 16'h8000}, {2'b01, 16'h7FFF}};
        logic [17:0] expS [2] = '{{2'b10, 16'h7FFF}, {2'b01, 16'h8000}};
        for (int k = 0; k < 2; k++) begin
            doReset();
            req0Vld = 1'b1; req0A = opA[k]; req0B = opB[k]; req0Sub = opS[k];
            nextCycle();
            req0Vld = 1'b0;
            nextCycle();
            rsp0Rdy = 1'b1;
            @(negedge clk);
            testsRun++;
            if ({wRsp0Vld, wRsp0Pos, wRsp0Neg, wRsp0Sum} !== {1'b1, expW[k]}) begin
                failCount++;
                $display("[TB] FAIL ovfl_wrap_%0d: got vld=%b %h expected 1 %h",
                         k, wRsp0Vld, {wRsp0Pos, wRsp0Neg, wRsp0Sum}, expW[k]);
            end
            testsRun++;
            if ({sRsp0Vld, sRsp0Pos, sRsp0Neg, sRsp0Sum} !== {1'b1, expS[k]}) begin
                failCount++;
                $display("[TB] FAIL ovfl_sat_%0d: got vld=%b %h expected 1 %h",
                         k, sRsp0Vld, {sRsp0Pos, sRsp0Neg, sRsp0Sum}, expS[k]);
            end
            nextCycle();
            rsp0Rdy = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] expW, expS;
        doReset();
        req0Vld = 1'b1; req0A = pickOp(); req0B = pickOp(); req0Sub = 1'($urandom);
        expW = refResult(req0A, req0B, req0Sub, 1'b0);
        expS = refResult(req0A, req0B, req0Sub, 1'b1);
        @(negedge clk);
        testsRun++;
        if ({wReq0Rdy, sReq0Rdy} !== 2'b11) begin
            failCount++;
            $display("[TB] FAIL bp_accept: got %b expected 11", {wReq0Rdy, sReq0Rdy});
        end
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            req0A = 16'($urandom); req0B = 16'($urandom); req0Sub = 1'($urandom);
            @(negedge clk);
            testsRun++;
            if ({wReq0Rdy, sReq0Rdy} !== 2'b00) begin
                failCount++;
                $display("[TB] FAIL bp_rdy_hold_%0d: got %b expected 00", k, {wReq0Rdy, sReq0Rdy});
            end
            if (k >= 2) begin
                testsRun++;
                if ({wRsp0Vld, wRsp0Pos, wRsp0Neg, wRsp0Sum, sRsp0Vld, sRsp0Pos, sRsp0Neg, sRsp0Sum} !==
                    {1'b1, expW, 1'b1, expS}) begin
                    failCount++;
                    $display("[TB] FAIL bp_rsp_stable_%0d: got %b %h / %b %h expected 1 %h / 1 %h", k,
                             wRsp0Vld, {wRsp0Pos, wRsp0Neg, wRsp0Sum},
                             sRsp0Vld, {sRsp0Pos, sRsp0Neg, sRsp0Sum}, expW, expS);
                end
            end
        end
        nextCycle();
        rsp0Rdy = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, sRsp0Vld, wReq0Rdy, sReq0Rdy} !== 4'b1100) begin
            failCount++;
            $display("[TB] FAIL bp_handoff_cycle: got %b expected 1100", {wRsp0Vld, sRsp0Vld, wReq0Rdy, sReq0Rdy});
        end
        nextCycle();
        rsp0Rdy = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wRsp0Vld, sRsp0Vld, wReq0Rdy, sReq0Rdy} !== 4'b0011) begin
            failCount++;
            $display("[TB] FAIL bp_after_handoff: got %b expected 0011", {wRsp0Vld, sRsp0Vld, wReq0Rdy, sReq0Rdy});
        end
        nextCycle();
        req0Vld = 1'b0;
    endtask

    task automatic test_reset_inflight();
        logic [17:0] expW, expS;
        doReset();
        req1Vld = 1'b1; req1A = 16'h1234; req1B = 16'h0101; req1Sub = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wReq1Rdy, sReq1Rdy} !== 2'b11) begin
            failCount++;
            $display("[TB] FAIL rinf_accept: got %b expected 11", {wReq1Rdy, sReq1Rdy});
        end
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({wReq1Rdy, sReq1Rdy} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL rinf_reset_rdy: got %b expected 00", {wReq1Rdy, sReq1Rdy});
        end
        nextCycle();
        rst = 1'b0; req1A = 16'h4000; req1B = 16'h0022; req1Sub = 1'b1;
        expW = refResult(req1A, req1B, req1Sub, 1'b0);
        expS = refResult(req1A, req1B, req1Sub, 1'b1);
        @(negedge clk);
        testsRun++;
        if ({wReq1Rdy, sReq1Rdy, wRsp1Vld, sRsp1Vld} !== 4'b1100) begin
            failCount++;
            $display("[TB] FAIL rinf_regrant: got %b expected 1100", {wReq1Rdy, sReq1Rdy, wRsp1Vld, sRsp1Vld});
        end
        nextCycle();
        req1Vld = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({wRsp1Vld, sRsp1Vld} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL rinf_no_stale_rsp: got %b expected 00", {wRsp1Vld, sRsp1Vld});
        end
        nextCycle();
        rsp1Rdy = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({wRsp1Vld, wRsp1Pos, wRsp1Neg, wRsp1Sum, sRsp1Vld, sRsp1Pos, sRsp1Neg, sRsp1Sum} !==
            {1'b1, expW, 1'b1, expS}) begin
            failCount++;
            $display("[TB] FAIL rinf_new_rsp: got %b %h / %b %h expected 1 %h / 1 %h",
                     wRsp1Vld, {wRsp1Pos, wRsp1Neg, wRsp1Sum}, sRsp1Vld, {sRsp1Pos, sRsp1Neg, sRsp1Sum}, expW, expS);
        end
        nextCycle();
        rsp1Rdy = 1'b0;
    endtask

    // Transaction-level model: each requester has at most one outstanding result that becomes visible two cycles after its grant.
    task automatic test_random(input int cycles);
        bit          outst [2];
        int          due [2];
        logic [17:0] expRes [2][2];
        bit          lastWinner;
        bit [1:0]    vld, rspRdy, expG, vis;
        bit          pValid;
        logic [32:0] pOps;
        logic        aRdy [2][2];
        logic        aVld [2][2];
        logic [17:0] aRes [2][2];
        logic [32:0] aAdd [2];
        logic [32:0] expAdd;
        logic [15:0] oa, ob;
        logic        os;
        doReset();
        outst = '{0, 0}; due = '{0, 0}; lastWinner = 1'b1; pValid = 1'b0; pOps = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            vld[0] = ($urandom_range(0, 3) != 0);
            vld[1] = ($urandom_range(0, 3) != 0);
            rspRdy[0] = ($urandom_range(0, 2) != 0);
            rspRdy[1] = ($urandom_range(0, 2) != 0);
            req0Vld = vld[0]; req1Vld = vld[1]; rsp0Rdy = rspRdy[0]; rsp1Rdy = rspRdy[1];
            req0A = pickOp(); req0B = pickOp(); req0Sub = 1'($urandom);
            req1A = pickOp(); req1B = pickOp(); req1Sub = 1'($urandom);
            @(negedge clk);
            aRdy = '{'{wReq0Rdy, wReq1Rdy}, '{sReq0Rdy, sReq1Rdy}};
            aVld = '{'{wRsp0Vld, wRsp1Vld}, '{sRsp0Vld, sRsp1Vld}};
            aRes = '{'{{wRsp0Pos, wRsp0Neg, wRsp0Sum}, {wRsp1Pos, wRsp1Neg, wRsp1Sum}},
                     '{{sRsp0Pos, sRsp0Neg, sRsp0Sum}, {sRsp1Pos, sRsp1Neg, sRsp1Sum}}};
            aAdd = '{{wAddA, wAddB, wAddSub}, {sAddA, sAddB, sAddSub}};
            expG = 2'b00;
            if (vld[0] && !outst[0] && vld[1] && !outst[1]) begin
                expG[lastWinner ? 0 : 1] = 1'b1;
            end else begin
                expG[0] = vld[0] && !outst[0];
                expG[1] = vld[1] && !outst[1];
            end
            expAdd = pValid ? pOps : 33'h0;
            for (int r = 0; r < 2; r++) vis[r] = outst[r] && (cyc >= due[r]);
            for (int d = 0; d < 2; d++) begin
                testsRun++;
                if (aAdd[d] !== expAdd) begin
                    failCount++;
                    $display("[TB] FAIL rnd_add_ops cyc=%0d dut=%0d: got %h expected %h", cyc, d, aAdd[d], expAdd);
                end
                for (int r = 0; r < 2; r++) begin
                    testsRun++;
                    if (aRdy[d][r] !== expG[r]) begin
                        failCount++;
                        $display("[TB] FAIL rnd_rdy cyc=%0d dut=%0d req=%0d: got %b expected %b",
                                 cyc, d, r, aRdy[d][r], expG[r]);
                    end
                    testsRun++;
                    if (aVld[d][r] !== vis[r]) begin
                        failCount++;
                        $display("[TB] FAIL rnd_rsp_vld cyc=%0d dut=%0d req=%0d: got %b expected %b",
                                 cyc, d, r, aVld[d][r], vis[r]);
                    end
                    if (vis[r]) begin
                        testsRun++;
                        if (aRes[d][r] !== expRes[r][d]) begin
                            failCount++;
                            $display("[TB] FAIL rnd_rsp_val cyc=%0d dut=%0d req=%0d: got %h expected %h",
                                     cyc, d, r, aRes[d][r], expRes[r][d]);
                        end
                    end
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (vis[r] && rspRdy[r]) outst[r] = 1'b0;
            end
            pValid = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (expG[r]) begin
                    oa = (r == 1) ? req1A : req0A;
                    ob = (r == 1) ? req1B : req0B;
                    os = (r == 1) ? req1Sub : req0Sub;
                    outst[r] = 1'b1;
                    due[r] = cyc + 2;
                    expRes[r][0] = refResult(oa, ob, os, 1'b0);
                    expRes[r][1] = refResult(oa, ob, os, 1'b1);
                    lastWinner = (r == 1);
                    pValid = 1'b1;
                    pOps = {oa, ob, os};
                end
            end
            nextCycle();
        end
        req0Vld = 1'b0; req1Vld = 1'b0; rsp0Rdy = 1'b0; rsp1Rdy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_reset_inflight();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
